dp_mem_initiator: RTL and testbench

//   Host-side initiator for the banked dual-port Hamming memory. Accepts one request per valid/ready handshake.

---
 rtl/dp_mem_pkg.sv | 26 ++
 rtl/dp_mem_rd_capture.sv | 46 ++++
 rtl/dp_mem_initiator.sv | 160 ++++++++++++++++
 tb/tb_dp_mem_initiator.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_mem_pkg.sv
// Shared constants, FSM state type and address helper for the dual-port memory initiator.
package dp_mem_pkg;

  localparam int unsigned AW        = 5;
  localparam int unsigned DW        = 8;
  localparam int unsigned BURST_LEN = 4;
  localparam int unsigned OFS_W     = 3;
  localparam int unsigned RD_LAT    = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR    = 3'd1,
    ST_RD    = 3'd2,
    ST_DRAIN = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  // Only the in-bank offset advances; bank and any middle bits are kept.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] addr,
                                              input logic [OFS_W-1:0] k);
    logic [OFS_W-1:0] ofs;
    ofs = addr[OFS_W-1:0] + k;
    return {addr[AW-1:OFS_W], ofs};
  endfunction

endpackage

// File: rtl/dp_mem_rd_capture.sv
// Read-beat tag pipe and beat-indexed capture register for the memory initiator.
module dp_mem_rd_capture #(
  parameter int unsigned DW        = 8,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned IDX_W     = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_clr,
  input  logic                    i_issue,
  input  logic [IDX_W-1:0]        i_idx,
  input  logic [DW-1:0]           i_rdata,
  output logic [DW*BURST_LEN-1:0] o_data
);

  logic [RD_LAT-1:0]      r_vld;
  logic [IDX_W-1:0]       r_idx [RD_LAT];
  logic [DW*BURST_LEN-1:0] r_data;

  // The tag leaves the pipe in the cycle the matching read data is on i_rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= '0;
      r_data <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        r_idx[i] <= '0;
      end
    end else begin
      r_vld[0] <= i_issue;
      r_idx[0] <= i_idx;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_idx[i] <= r_idx[i-1];
      end
      if (i_clr) begin
        r_data <= '0;
      end else if (r_vld[RD_LAT-1]) begin
        r_data[r_idx[RD_LAT-1]*DW +: DW] <= i_rdata;
      end
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/dp_mem_initiator.sv
// Host-side initiator: splits requests into single-beat memory cycles and returns one response each.
module dp_mem_initiator
  import dp_mem_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wr,
  input  logic                    req_burst,
  input  logic [AW-1:0]           req_addr,
  input  logic [DW*BURST_LEN-1:0] req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_wr,
  output logic [DW*BURST_LEN-1:0] rsp_rdata,
  output logic                    busy,
  output logic                    mem_enb,
  output logic                    mem_wr,
  output logic                    mem_rd,
  output logic                    mem_burst,
  output logic [AW-1:0]           mem_w_addr,
  output logic [AW-1:0]           mem_r_addr,
  output logic [DW-1:0]           mem_w_data,
  input  logic [DW-1:0]           mem_r_data
);

  localparam int unsigned BEAT_W = $clog2(BURST_LEN + 1);
  localparam int unsigned IDX_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned DRN_W  = $clog2(RD_LAT + 1);
  localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(RD_LAT - 1);

  state_t                  r_state;
  logic                    r_wr;
  logic                    r_burst;
  logic [AW-1:0]           r_addr;
  logic [DW*BURST_LEN-1:0] r_wdata;
  logic [BEAT_W-1:0]       r_beat;
  logic [DRN_W-1:0]        r_drain;
  logic                    r_mem_enb;
  logic                    r_mem_wr;
  logic                    r_mem_rd;
  logic [AW-1:0]           r_mem_w_addr;
  logic [AW-1:0]           r_mem_r_addr;
  logic [DW-1:0]           r_mem_w_data;
  logic [IDX_W-1:0]        r_mem_idx;

  logic [BEAT_W-1:0]       w_n;
  logic [IDX_W-1:0]        w_idx;
  logic [AW-1:0]           w_addr;
  logic [DW-1:0]           w_wbeat;
  logic                    w_clr;

  assign w_n     = r_burst ? BEAT_W'(BURST_LEN) : BEAT_W'(1);
  assign w_idx   = r_beat[IDX_W-1:0];
  assign w_addr  = next_addr(r_addr, OFS_W'(r_beat));
  assign w_wbeat = r_wdata[w_idx*DW +: DW];
  assign w_clr   = (r_state == ST_RESP) && rsp_ready;

  // Strobes are registered, so each WR/RD state spends one extra cycle
  // retiring the last beat before moving on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_wr         <= 1'b0;
      r_burst      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_beat       <= '0;
      r_drain      <= '0;
      r_mem_enb    <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_rd     <= 1'b0;
      r_mem_w_addr <= '0;
      r_mem_r_addr <= '0;
      r_mem_w_data <= '0;
      r_mem_idx    <= '0;
    end else begin
      r_mem_enb <= 1'b0;
      r_mem_wr  <= 1'b0;
      r_mem_rd  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_wr    <= req_wr;
            r_burst <= req_burst;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_beat  <= '0;
            r_state <= req_wr ? ST_WR : ST_RD;
          end
        end
        ST_WR: begin
          if (r_beat != w_n) begin
            r_mem_enb    <= 1'b1;
            r_mem_wr     <= 1'b1;
            r_mem_w_addr <= w_addr;
            r_mem_w_data <= w_wbeat;
            r_beat       <= r_beat + BEAT_W'(1);
          end else begin
            r_state <= ST_RESP;
          end
        end
        ST_RD: begin
          if (r_beat != w_n) begin
            r_mem_enb    <= 1'b1;
            r_mem_rd     <= 1'b1;
            r_mem_r_addr <= w_addr;
            r_mem_idx    <= w_idx;
            r_beat       <= r_beat + BEAT_W'(1);
          end else begin
            r_drain <= '0;
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (r_drain == DRAIN_LAST) begin
            r_state <= ST_RESP;
          end else begin
            r_drain <= r_drain + DRN_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  dp_mem_rd_capture #(
    .DW        (DW),
    .BURST_LEN (BURST_LEN),
    .RD_LAT    (RD_LAT),
    .IDX_W     (IDX_W)
  ) u_capture (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_clr),
    .i_issue (r_mem_rd),
    .i_idx   (r_mem_idx),
    .i_rdata (mem_r_data),
    .o_data  (rsp_rdata)
  );

  assign req_ready  = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign rsp_valid  = (r_state == ST_RESP);
  assign rsp_wr     = rsp_valid & r_wr;
  assign mem_enb    = r_mem_enb;
  assign mem_wr     = r_mem_wr;
  assign mem_rd     = r_mem_rd;
  assign mem_burst  = 1'b0;
  assign mem_w_addr = r_mem_w_addr;
  assign mem_r_addr = r_mem_r_addr;
  assign mem_w_data = r_mem_w_data;

endmodule

// File: tb/tb_dp_mem_initiator.sv
// Self-checking bench for dp_mem_initiator: vector table, corner sequences, random traffic vs. a shadow model.
module tb_dp_mem_initiator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic        req_burst = 1'b0;
  logic [4:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_wr;
  logic [31:0] rsp_rdata;
  logic        busy;
  logic        mem_enb, mem_wr, mem_rd, mem_burst;
  logic [4:0]  mem_w_addr, mem_r_addr;
  logic [7:0]  mem_w_data, mem_r_data;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  dp_mem_initiator dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_burst(req_burst),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr), .rsp_rdata(rsp_rdata),
    .busy(busy), .mem_enb(mem_enb), .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_burst(mem_burst),
    .mem_w_addr(mem_w_addr), .mem_r_addr(mem_r_addr), .mem_w_data(mem_w_data),
    .mem_r_data(mem_r_data)
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  // Memory device: registered read with one cycle latency, plus a backdoor loader.
  logic [7:0] mem    [32];
  logic [7:0] refmem [32];
  logic       bd_we = 1'b0;
  logic [4:0] bd_addr = '0;
  logic [7:0] bd_data = '0;
  logic [7:0] rd_q = '0;
  assign mem_r_data = rd_q;

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (mem_enb && mem_wr) mem[mem_w_addr] <= mem_w_data;
    if (mem_enb && mem_rd) rd_q <= mem[mem_r_addr];
  end

  typedef struct {
    logic       wr;
    logic [4:0] addr;
    logic [7:0] data;
  } beat_t;
  beat_t bus_q[$];

  always @(negedge clk) begin
    chk("wr_rd_exclusive", {31'd0, mem_wr & mem_rd}, 32'd0);
    chk("mem_burst_zero", {31'd0, mem_burst}, 32'd0);
    chk("busy_vs_ready", {31'd0, busy}, {31'd0, ~req_ready});
    if (mem_enb) bus_q.push_back('{mem_wr, mem_wr ? mem_w_addr : mem_r_addr, mem_w_data});
  end

  // Address of beat k: offset wraps inside its 8-entry bank, upper bits untouched.
  function automatic logic [4:0] m_addr(input logic [4:0] a, input int unsigned k);
    int unsigned base, ofs;
    base = int'(a) - (int'(a) % 8);
    ofs  = (int'(a) % 8 + k) % 8;
    return 5'(base + ofs);
  endfunction

  task automatic preload(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
    refmem[a] = d;
  endtask

  task automatic run_txn(input string nm, input logic wr, input logic burst, input logic [4:0] addr,
                         input logic [31:0] wdata, input int unsigned hold, input int unsigned exp_lat,
                         input logic [19:0] exp_addrs, input logic [31:0] exp_rdata);
    int unsigned lat, waited, exp_n;
    logic [31:0] held;
    exp_n = burst ? 4 : 1;
    @(negedge clk);
    req_valid = 1'b1; req_wr = wr; req_burst = burst; req_addr = addr; req_wdata = wdata;
    waited = 0;
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk({nm, ".accept"}, {31'd0, req_ready}, 32'd1);
    bus_q.delete();
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wr = 1'($urandom); req_burst = 1'($urandom); req_addr = 5'($urandom); req_wdata = $urandom;
    lat = 0;
    while (!rsp_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, ".latency"}, lat, exp_lat);
    chk({nm, ".rsp_wr"}, {31'd0, rsp_wr}, {31'd0, wr});
    chk({nm, ".rdata"}, rsp_rdata, exp_rdata);
    held = rsp_rdata;
    for (int unsigned h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({nm, ".hold_valid"}, {31'd0, rsp_valid}, 32'd1);
      chk({nm, ".hold_rdata"}, rsp_rdata, held);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({nm, ".rsp_done"}, {31'd0, rsp_valid}, 32'd0);
    chk({nm, ".ready_after"}, {31'd0, req_ready}, 32'd1);
    chk({nm, ".rdata_clr"}, rsp_rdata, 32'd0);
    chk({nm, ".nbeats"}, bus_q.size(), exp_n);
    for (int unsigned k = 0; k < exp_n && k < bus_q.size(); k++) begin
      chk($sformatf("%s.beat%0d_addr", nm, k), {27'd0, bus_q[k].addr}, {27'd0, exp_addrs[k*5 +: 5]});
      chk($sformatf("%s.beat%0d_wr", nm, k), {31'd0, bus_q[k].wr}, {31'd0, wr});
      if (wr) chk($sformatf("%s.beat%0d_data", nm, k), {24'd0, bus_q[k].data}, {24'd0, wdata[k*8 +: 8]});
    end
  endtask

  typedef struct {
    logic        wr;
    logic        burst;
    logic [4:0]  addr;
    logic [31:0] wdata;
    int unsigned hold;
    int unsigned lat;
    logic [19:0] addrs;
    logic [31:0] rdata;
  } vec_t;

  initial begin
    vec_t        tbl [6];
    int          last;
    int unsigned guard, n, lat;
    logic        wr, burst;
    logic [4:0]  a;
    logic [31:0] wd, rd;
    logic [19:0] ea;

    tbl[0] = '{1'b1, 1'b0, 5'h03, 32'h0000_00A5, 0, 2, {15'd0, 5'h03}, 32'h0};
    tbl[1] = '{1'b1, 1'b1, 5'h16, 32'h4433_2211, 1, 5, {5'h11, 5'h10, 5'h17, 5'h16}, 32'h0};
    tbl[2] = '{1'b0, 1'b0, 5'h05, 32'h0, 0, 3, {15'd0, 5'h05}, 32'h0000_003C};
    tbl[3] = '{1'b0, 1'b1, 5'h0E, 32'h0, 5, 6, {5'h09, 5'h08, 5'h0F, 5'h0E}, 32'hD4D3_D2D1};
    tbl[4] = '{1'b0, 1'b1, 5'h16, 32'h0, 2, 6, {5'h11, 5'h10, 5'h17, 5'h16}, 32'h4433_2211};
    tbl[5] = '{1'b0, 1'b0, 5'h03, 32'h0, 0, 3, {15'd0, 5'h03}, 32'h0000_00A5};

    #3;
    chk("rst.req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.mem_ctl", {29'd0, mem_enb, mem_wr, mem_rd}, 32'd0);
    chk("rst.addrs", {22'd0, mem_w_addr, mem_r_addr}, 32'd0);
    chk("rst.w_data", {24'd0, mem_w_data}, 32'd0);
    chk("rst.rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int unsigned i = 0; i < 32; i++) preload(5'(i), 8'($urandom));
    preload(5'h05, 8'h3C);
    preload(5'h0E, 8'hD1);
    preload(5'h0F, 8'hD2);
    preload(5'h08, 8'hD3);
    preload(5'h09, 8'hD4);

    for (int unsigned t = 0; t < 6; t++) begin
      run_txn($sformatf("vec%0d", t), tbl[t].wr, tbl[t].burst, tbl[t].addr, tbl[t].wdata,
              tbl[t].hold, tbl[t].lat, tbl[t].addrs, tbl[t].rdata);
      if (tbl[t].wr) begin
        n = tbl[t].burst ? 4 : 1;
        for (int unsigned k = 0; k < n; k++) refmem[m_addr(tbl[t].addr, k)] = tbl[t].wdata[k*8 +: 8];
      end
    end

    // Reset asserted while the second beat of a burst write is on the bus.
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_burst = 1'b1; req_addr = 5'h1A; req_wdata = 32'h5D4C_3B2A;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rstmid.beat0_enb", {31'd0, mem_enb}, 32'd1);
    @(posedge clk); #1;
    chk("rstmid.beat1_addr", {27'd0, mem_w_addr}, 32'h1B);
    chk("rstmid.beat1_data", {24'd0, mem_w_data}, 32'h3B);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid.enb_drop", {31'd0, mem_enb}, 32'd0);
    chk("rstmid.wr_drop", {31'd0, mem_wr}, 32'd0);
    chk("rstmid.ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int unsigned c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("rstmid.no_rsp", {31'd0, rsp_valid}, 32'd0);
      chk("rstmid.idle", {31'd0, req_ready}, 32'd1);
    end
    refmem[5'h1A] = 8'h2A;

    // Request held high with the response channel always ready.
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_wr = 1'b1; req_burst = 1'b0; req_addr = 5'h07; req_wdata = 32'h0000_0077;
    last = -1;
    for (int c = 0; c < 40; c++) begin
      if (req_ready) begin
        if (last >= 0) chk("b2b.gap", 32'(c - last), 32'd4);
        last = c;
      end
      @(negedge clk);
    end
    chk("b2b.accepted", {31'd0, last >= 0}, 32'd1);
    req_valid = 1'b0;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("b2b.drain_idle", {31'd0, req_ready}, 32'd1);
    rsp_ready = 1'b0;
    refmem[5'h07] = 8'h77;

    for (int unsigned t = 0; t < 40; t++) begin
      wr = 1'($urandom); burst = 1'($urandom); a = 5'($urandom); wd = $urandom;
      n = burst ? 4 : 1;
      lat = wr ? n + 1 : n + 2;
      ea = '0; rd = '0;
      for (int unsigned k = 0; k < n; k++) begin
        ea[k*5 +: 5] = m_addr(a, k);
        if (!wr) rd[k*8 +: 8] = refmem[m_addr(a, k)];
      end
      run_txn($sformatf("rnd%0d", t), wr, burst, a, wd, $urandom_range(0, 2), lat, ea, rd);
      if (wr) for (int unsigned k = 0; k < n; k++) refmem[m_addr(a, k)] = wd[k*8 +: 8];
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
